seq_serializer: RTL
===================

SEQ_SERIALIZER -- requirements
Module: seq_serializer

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (2..32).
REQ-002 Parameter MSB_FIRST, default 1; 1 = MSB transmitted first, 0 = LSB first.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_data  input  WIDTH  parallel word to serialize.
REQ-006 in_valid  input  1  in_data valid; word accepted on a rising edge with in_valid & in_ready.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 x  output  1  serial bit stream to the downstream sequence detector.
REQ-009 x_valid  output  1  x carries a real bit this cycle.
REQ-010 word_done  output  1  one-cycle pulse coincident with the last bit of a word.

Function
REQ-011 Storage: one shift register, one hold register (hold_full flag), bit counter of ceil(log2(WIDTH+1)) bits.
REQ-012 States: IDLE (no valid bit), SHIFT (data bits), PARITY (only with SER_PARITY_EN).
REQ-013 in_ready = !hold_full, registered; 0 while rst is high.
REQ-014 In IDLE, an accepted word loads directly into the shift register; x_valid = 1 with the first bit on the next cycle.
REQ-015 In SHIFT, each bit is driven for exactly one cycle; bit order per MSB_FIRST.
REQ-016 A word accepted during SHIFT goes to the hold register; hold_full = 1 from the next cycle.
REQ-017 On the last bit cycle, word_done = 1.
REQ-018 At the edge ending the last bit: hold_full -> hold moves to shift reg, hold_full clears, SHIFT restarts with zero gap; else if a word is accepted at that same edge it loads directly into the shift reg (zero gap); else -> IDLE.
REQ-019 x = 0 whenever x_valid = 0.
REQ-020 in_valid without in_ready is ignored; in_data is not sampled.
REQ-021 Continuous in_valid yields an unbroken x_valid stream of WIDTH bits per word.

Reset
REQ-022 rst high forces immediately: state IDLE, x = 0, x_valid = 0, word_done = 0, hold_full = 0, counter = 0, in_ready = 0.
REQ-023 Reset mid-word discards the word in flight and any held word; no partial word resumes.
REQ-024 First cycle after rst release: in_ready = 1, x_valid = 0.

Configuration
REQ-025 Macro SER_PARITY_EN: defined -> after the last data bit, PARITY state drives one even-parity bit (XOR of the word); word_done moves to the parity cycle; words occupy WIDTH+1 cycles.
REQ-026 Without SER_PARITY_EN: PARITY state and parity logic absent; words occupy WIDTH cycles.

Structure
REQ-027 Package seq_pkg holds the state enum (IDLE, SHIFT, PARITY) and constant SEQ_WIDTH_DEFAULT = 8.
REQ-028 Single module; no sub-module. Parity is an inline XOR reduction.

Verification
REQ-029 Load 8'hB5, MSB_FIRST=1 -> x = 1,0,1,1,0,1,0,1 on cycles 1..8 after accept; word_done on cycle 8; x_valid = 0 on cycle 9.
REQ-030 Same word, MSB_FIRST=0 -> x = 1,0,1,0,1,1,0,1.
REQ-031 Back-to-back 8'hB5 then 8'h0F, in_valid held high -> 16 contiguous x_valid cycles; in_ready = 0 while hold is full; word_done on cycles 8 and 16.
REQ-032 rst asserted during bit 3 of 8'hB5 -> x_valid = 0 and x = 0 immediately; after release, no bits until a new accept.
REQ-033 SER_PARITY_EN, 8'hB5 -> 9 bits, 9th = 1; word_done on the 9th; 8'h0F -> 9th = 0.
REQ-034 Word accepted on the exact last-bit edge with hold empty -> next word's first bit on the following cycle, no gap.

Source files
------------

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding and defaults for the bit serializer
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_t;

  localparam int SEQ_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/seq_serializer.sv
// rtl/seq_serializer.sv - parallel word to serial bit stream with one-word hold buffer
// Optional trailing even-parity bit when SER_PARITY_EN is defined.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH     = SEQ_WIDTH_DEFAULT,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] shift_q, hold_q, shifted;
  logic [CW-1:0]    cnt;
  logic             hold_full, hold_full_next, ready_q;
  logic             accept, cur_bit, word_end;
  logic             load_new, load_hold, store_hold;
`ifdef SER_PARITY_EN
  logic             par_q;
`endif

  assign in_ready = ready_q;
  assign accept   = in_valid & ready_q;
  assign cur_bit  = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
  assign shifted  = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
  assign hold_full_next = store_hold | (hold_full & ~load_hold);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    x          = 1'b0;
    x_valid    = 1'b0;
    word_done  = 1'b0;
    word_end   = 1'b0;
    load_new   = 1'b0;
    load_hold  = 1'b0;
    store_hold = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SHIFT;
          load_new   = 1'b1;
        end
      end
      SHIFT: begin
        x_valid = 1'b1;
        x       = cur_bit;
        if (cnt == LAST_BIT) begin
`ifdef SER_PARITY_EN
          state_next = PARITY;
          store_hold = accept;
`else
          word_end = 1'b1;
`endif
        end else begin
          store_hold = accept;
        end
      end
`ifdef SER_PARITY_EN
      PARITY: begin
        x_valid  = 1'b1;
        x        = par_q;
        word_end = 1'b1;
      end
`endif
      default: state_next = IDLE;
    endcase
    // Last cycle of a word: chain straight into the held or newly offered word.
    if (word_end) begin
      word_done = 1'b1;
      if (hold_full) begin
        load_hold  = 1'b1;
        state_next = SHIFT;
      end else if (accept) begin
        load_new   = 1'b1;
        state_next = SHIFT;
      end else begin
        state_next = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q   <= '0;
      hold_q    <= '0;
      cnt       <= '0;
      hold_full <= 1'b0;
      ready_q   <= 1'b0;
`ifdef SER_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      hold_full <= hold_full_next;
      ready_q   <= ~hold_full_next;
      if (store_hold) hold_q <= in_data;
      if (load_new) begin
        shift_q <= in_data;
        cnt     <= '0;
      end else if (load_hold) begin
        shift_q <= hold_q;
        cnt     <= '0;
      end else if (state == SHIFT) begin
        shift_q <= shifted;
        cnt     <= (state_next == IDLE) ? '0 : cnt + CW'(1);
      end else begin
        cnt     <= '0;
      end
`ifdef SER_PARITY_EN
      if (load_new)       par_q <= ^in_data;
      else if (load_hold) par_q <= ^hold_q;
`endif
    end
  end

endmodule
